ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Producer side of the execute-stage bypass.
- Owns the D/X, X/M and M/W control-word pipeline registers that the bypass unit compares for forwarding.
- Inserts bubbles for load-use hazards, squashes wrong-path instructions on a taken branch or jump, and holds the pipe while a multiply/divide is in flight.
- Sits between decode and the execute/memory/writeback stages of the 5-stage CPU.

Parameters:
- MD_MAX_CYCLES, 40, maximum MD_WAIT cycles before forced release and sticky timeout flag.
- CW, 32, control-word width (fixed field layout below).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- ctrl_fd_in  input  32  decoded control word of the instruction in decode.
- fd_rt  input  5  second source register of the instruction in decode.
- fd_uses_rt  input  1  decode instruction reads fd_rt.
- flush  input  1  taken branch, jump or bex resolved for the instruction in D/X.
- md_op_dx  input  1  instruction in D/X is mult/div.
- md_ready  input  1  multdiv result valid this cycle.
- ctrl_dx  output  32  D/X control word.
- ctrl_xm  output  32  X/M control word.
- ctrl_mw  output  32  M/W control word.
- stall_fd  output  1  hold PC and F/D latch this cycle (combinational).
- md_busy  output  1  state == MD_WAIT.
- md_timeout  output  1  sticky: an MD_WAIT was force-released.

Behaviour:
- Control-word layout:
  - [31:27] rd, [26:22] shamt, [21:17] aluop, [16] aluInB
  - [15] RWE, [14] Dmem_WE, [13] mem_to_reg
  - [12] bne, [11] blt, [10] br, [9] jp, [8] jal, [7] jr, [6] bex
  - [5:0] rs, with [5] always 0
- Bubble = 32'h0 (no write, no memory access, rd=0).
- Reset:
  - ctrl_dx = ctrl_xm = ctrl_mw = 0.
  - State = RUN; MD cycle counter = 0; md_timeout = 0.
  - stall_fd = 0 while reset is high.
- Capture rule: on every load into D/X, if ctrl_fd_in[15]==0 the rd field is written as 0, so the bypass unit never matches a non-writing instruction.
- Load-use hazard (combinational, RUN only):
  - Condition: ctrl_dx[13]=1 and ctrl_dx[31:27]!=0, and either ctrl_fd_in[4:0]==ctrl_dx[31:27] or (fd_uses_rt and fd_rt==ctrl_dx[31:27]).
- RUN state, per cycle, in priority order:
  1. flush: dx<=0, xm<=dx, mw<=xm, stall_fd=0. The decode instruction is discarded. Flush overrides load-use.
  2. md_op_dx: dx held, xm<=0, mw<=xm, stall_fd=1, counter<=1, next state MD_WAIT.
  3. load-use: dx<=0, xm<=dx, mw<=xm, stall_fd=1. Exactly one bubble per hazard.
  4. Otherwise: dx<=ctrl_fd_in (with capture rule), xm<=dx, mw<=xm, stall_fd=0.
- MD_WAIT state:
  - md_ready=1: xm<=dx, dx<=ctrl_fd_in (capture rule), mw<=xm, stall_fd=0, counter<=0, next RUN. Load-use is not evaluated in this cycle because dx holds the md op, which has mem_to_reg=0.
  - md_ready=0 and counter==MD_MAX_CYCLES: same as md_ready=1, and md_timeout<=1.
  - Otherwise: dx held, xm<=0, mw<=xm, stall_fd=1, counter+1.
  - flush is ignored in MD_WAIT.
- md_ready in RUN is ignored.
- Reset asserted in MD_WAIT: return to RUN with all registers cleared on that edge; md_timeout is cleared.
- Counter width: clog2(MD_MAX_CYCLES+1); it never wraps.

Test Plan:
- Reset, then stream three ALU words 32'h0800_8001, 32'h1000_8002, 32'h1800_8003 -> each appears on dx, xm and mw in consecutive cycles; stall_fd=0 throughout.
- dx = load (rd=5, bit13=1, RWE=1) with ctrl_fd_in rs=5 -> stall_fd=1 for one cycle; next cycle dx=0, xm=load word; decode word enters dx one cycle later. Repeat with fd_rt=5, fd_uses_rt=1 -> same. Repeat with rd=0 -> no stall.
- Load in dx creates a hazard and flush=1 in the same cycle -> stall_fd=0, dx<=0, xm<=load word.
- md_op_dx=1, md_ready rises after 4 cycles -> md_busy high 4 cycles; xm=0 each wait cycle; mw drains; on the ready cycle xm=md word and dx=next decode word.
- MD_MAX_CYCLES=8 with md_ready held 0 -> release on the 8th wait cycle; md_timeout=1 and stays 1 until reset.
- ctrl_fd_in with RWE=0 and rd=7 -> ctrl_dx[31:27]=0. Reset asserted mid-MD_WAIT -> next cycle all outputs 0, md_busy=0.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control-word pipeline for the D/X, X/M and M/W stages feeding the execute-stage bypass.
// Handles load-use bubbles, wrong-path squash on flush, and stalls while a multiply/divide is in flight.
module ctrl_pipe #(
    parameter int MD_MAX_CYCLES = 40,
    parameter int CW            = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] ctrl_fd_in,
    input  logic [4:0]    fd_rt,
    input  logic          fd_uses_rt,
    input  logic          flush,
    input  logic          md_op_dx,
    input  logic          md_ready,
    output logic [CW-1:0] ctrl_dx,
    output logic [CW-1:0] ctrl_xm,
    output logic [CW-1:0] ctrl_mw,
    output logic          stall_fd,
    output logic          md_busy,
    output logic          md_timeout
);

    localparam int CNT_W = $clog2(MD_MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    dx_q, dx_d;
    logic [CW-1:0]    xm_q, xm_d;
    logic [CW-1:0]    mw_q, mw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             stall_s;
    logic             load_use_s;
    logic [CW-1:0]    fd_cap_s;
    logic             md_release_s;

    // A non-writing instruction must never present a matchable rd to the bypass unit.
    function automatic logic [CW-1:0] capture_word(input logic [CW-1:0] w);
        logic [CW-1:0] r;
        if (w[15]) begin
            r = w;
        end else begin
            r = {5'b00000, w[CW-6:0]};
        end
        return r;
    endfunction

    // Load-use hazard detection against the load sitting in D/X.
    always_comb begin
        load_use_s = 1'b0;
        fd_cap_s   = capture_word(ctrl_fd_in);
        if (dx_q[13] && (dx_q[31:27] != 5'd0)) begin
            load_use_s = (ctrl_fd_in[4:0] == dx_q[31:27]) ||
                         (fd_uses_rt && (fd_rt == dx_q[31:27]));
        end else begin
            load_use_s = 1'b0;
        end
    end

    assign md_release_s = md_ready || (cnt_q == CNT_W'(MD_MAX_CYCLES));

    // Next-state, pipeline advance and decode-stall generation.
    always_comb begin
        state_d   = state_q;
        dx_d      = dx_q;
        xm_d      = xm_q;
        mw_d      = mw_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        stall_s   = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    mw_d = xm_q;
                    if (flush) begin
                        dx_d = '0;
                        xm_d = dx_q;
                    end else if (md_op_dx) begin
                        xm_d    = '0;
                        stall_s = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_MD_WAIT;
                    end else if (load_use_s) begin
                        dx_d    = '0;
                        xm_d    = dx_q;
                        stall_s = 1'b1;
                    end else begin
                        dx_d = fd_cap_s;
                        xm_d = dx_q;
                    end
                end
                ST_MD_WAIT: begin
                    mw_d = xm_q;
                    if (md_release_s) begin
                        xm_d    = dx_q;
                        dx_d    = fd_cap_s;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                        if (!md_ready) begin
                            timeout_d = 1'b1;
                        end else begin
                            timeout_d = timeout_q;
                        end
                    end else begin
                        xm_d    = '0;
                        stall_s = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    dx_d    = '0;
                    xm_d    = '0;
                    mw_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RUN;
            dx_q      <= '0;
            xm_q      <= '0;
            mw_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dx_q      <= dx_d;
            xm_q      <= xm_d;
            mw_q      <= mw_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ctrl_dx    = dx_q;
    assign ctrl_xm    = xm_q;
    assign ctrl_mw    = mw_q;
    assign stall_fd   = stall_s;
    assign md_busy    = (state_q == ST_MD_WAIT);
    assign md_timeout = timeout_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: streaming, load-use bubbles, flush, mult/div wait and timeout, reset.
module tb_ctrl_pipe;

    logic        clock;
    logic        reset;
    logic [31:0] ctrl_fd_in;
    logic [4:0]  fd_rt;
    logic        fd_uses_rt;
    logic        flush;
    logic        md_op_dx;
    logic        md_ready;
    logic [31:0] ctrl_dx;
    logic [31:0] ctrl_xm;
    logic [31:0] ctrl_mw;
    logic        stall_fd;
    logic        md_busy;
    logic        md_timeout;

    int n_cmp;
    int n_err;

    localparam logic [31:0] W1 = 32'h0800_8001;
    localparam logic [31:0] W2 = 32'h1000_8002;
    localparam logic [31:0] W3 = 32'h1800_8003;
    localparam logic [31:0] LD = 32'h2800_A002;  // rd=5, mem_to_reg, RWE
    localparam logic [31:0] DRS = 32'h3000_8005; // rs=5
    localparam logic [31:0] DRT = 32'h3000_8001; // rs=1
    localparam logic [31:0] LD0 = 32'h0000_A000; // rd=0 load
    localparam logic [31:0] D0 = 32'h3000_8000;  // rs=0
    localparam logic [31:0] MD = 32'h5000_8003;  // rd=10

    ctrl_pipe #(.MD_MAX_CYCLES(8), .CW(32)) dut (
        .clock(clock), .reset(reset), .ctrl_fd_in(ctrl_fd_in), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .flush(flush), .md_op_dx(md_op_dx), .md_ready(md_ready),
        .ctrl_dx(ctrl_dx), .ctrl_xm(ctrl_xm), .ctrl_mw(ctrl_mw), .stall_fd(stall_fd),
        .md_busy(md_busy), .md_timeout(md_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_fd_in = 32'hFFFF_FFFF; fd_rt = 5'd0; fd_uses_rt = 1'b0;
        flush = 1'b0; md_op_dx = 1'b0; md_ready = 1'b0;
        #1;
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", stall_fd); n_err++; end
        tick(); tick();
        n_cmp++; if (ctrl_dx !== 32'h0) begin $display("FAIL reset_dx got=%h exp=0", ctrl_dx); n_err++; end
        n_cmp++; if (ctrl_xm !== 32'h0) begin $display("FAIL reset_xm got=%h exp=0", ctrl_xm); n_err++; end
        n_cmp++; if (ctrl_mw !== 32'h0) begin $display("FAIL reset_mw got=%h exp=0", ctrl_mw); n_err++; end
        n_cmp++; if (md_busy !== 1'b0) begin $display("FAIL reset_busy got=%b exp=0", md_busy); n_err++; end
        n_cmp++; if (md_timeout !== 1'b0) begin $display("FAIL reset_timeout got=%b exp=0", md_timeout); n_err++; end
        ctrl_fd_in = 32'h0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] w [5];
        logic [31:0] exp_xm;
        logic [31:0] exp_mw;
        w[0] = W1; w[1] = W2; w[2] = W3; w[3] = 32'h0; w[4] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            ctrl_fd_in = w[i];
            #1;
            n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL stream_stall[%0d] got=%b exp=0", i, stall_fd); n_err++; end
            tick();
            exp_xm = (i >= 1) ? w[i-1] : 32'h0;
            exp_mw = (i >= 2) ? w[i-2] : 32'h0;
            n_cmp++; if (ctrl_dx !== w[i]) begin $display("FAIL stream_dx[%0d] got=%h exp=%h", i, ctrl_dx, w[i]); n_err++; end
            n_cmp++; if (ctrl_xm !== exp_xm) begin $display("FAIL stream_xm[%0d] got=%h exp=%h", i, ctrl_xm, exp_xm); n_err++; end
            n_cmp++; if (ctrl_mw !== exp_mw) begin $display("FAIL stream_mw[%0d] got=%h exp=%h", i, ctrl_mw, exp_mw); n_err++; end
        end
    endtask

    task automatic test_load_use();
        // rs match
        ctrl_fd_in = LD; tick();
        ctrl_fd_in = DRS; #1;
        n_cmp++; if (stall_fd !== 1'b1) begin $display("FAIL lu_rs_stall got=%b exp=1", stall_fd); n_err++; end
        tick();
        n_cmp++; if (ctrl_dx !== 32'h0) begin $display("FAIL lu_rs_bubble_dx got=%h exp=0", ctrl_dx); n_err++; end
        n_cmp++; if (ctrl_xm !== LD) begin $display("FAIL lu_rs_xm got=%h exp=%h", ctrl_xm, LD); n_err++; end
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL lu_rs_one_bubble got=%b exp=0", stall_fd); n_err++; end
        tick();
        n_cmp++; if (ctrl_dx !== DRS) begin $display("FAIL lu_rs_dx_next got=%h exp=%h", ctrl_dx, DRS); n_err++; end
        n_cmp++; if (ctrl_mw !== LD) begin $display("FAIL lu_rs_mw got=%h exp=%h", ctrl_mw, LD); n_err++; end
        // rt match
        ctrl_fd_in = LD; tick();
        ctrl_fd_in = DRT; fd_rt = 5'd5; fd_uses_rt = 1'b0; #1;
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL lu_rt_unused_stall got=%b exp=0", stall_fd); n_err++; end
        fd_uses_rt = 1'b1; #1;
        n_cmp++; if (stall_fd !== 1'b1) begin $display("FAIL lu_rt_stall got=%b exp=1", stall_fd); n_err++; end
        tick();
        n_cmp++; if (ctrl_dx !== 32'h0) begin $display("FAIL lu_rt_bubble_dx got=%h exp=0", ctrl_dx); n_err++; end
        n_cmp++; if (ctrl_xm !== LD) begin $display("FAIL lu_rt_xm got=%h exp=%h", ctrl_xm, LD); n_err++; end
        tick();
        n_cmp++; if (ctrl_dx !== DRT) begin $display("FAIL lu_rt_dx_next got=%h exp=%h", ctrl_dx, DRT); n_err++; end
        fd_rt = 5'd0; fd_uses_rt = 1'b0;
        // rd=0 load never stalls
        ctrl_fd_in = LD0; tick();
        ctrl_fd_in = D0; #1;
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL lu_rd0_stall got=%b exp=0", stall_fd); n_err++; end
        tick();
        n_cmp++; if (ctrl_dx !== D0) begin $display("FAIL lu_rd0_dx got=%h exp=%h", ctrl_dx, D0); n_err++; end
        ctrl_fd_in = 32'h0; tick();
    endtask

    task automatic test_flush_load();
        ctrl_fd_in = LD; tick();
        ctrl_fd_in = DRS; flush = 1'b1; #1;
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL flush_stall got=%b exp=0", stall_fd); n_err++; end
        tick();
        flush = 1'b0;
        n_cmp++; if (ctrl_dx !== 32'h0) begin $display("FAIL flush_dx got=%h exp=0", ctrl_dx); n_err++; end
        n_cmp++; if (ctrl_xm !== LD) begin $display("FAIL flush_xm got=%h exp=%h", ctrl_xm, LD); n_err++; end
        ctrl_fd_in = 32'h0; tick();
    endtask

    task automatic test_md_wait();
        ctrl_fd_in = W1; tick();
        ctrl_fd_in = MD; tick();
        md_op_dx = 1'b1; ctrl_fd_in = W2; #1;
        n_cmp++; if (stall_fd !== 1'b1) begin $display("FAIL md_enter_stall got=%b exp=1", stall_fd); n_err++; end
        tick();
        md_op_dx = 1'b0;
        n_cmp++; if (ctrl_mw !== W1) begin $display("FAIL md_mw_drain got=%h exp=%h", ctrl_mw, W1); n_err++; end
        for (int k = 1; k <= 3; k++) begin
            n_cmp++; if (md_busy !== 1'b1) begin $display("FAIL md_busy[%0d] got=%b exp=1", k, md_busy); n_err++; end
            n_cmp++; if (ctrl_xm !== 32'h0) begin $display("FAIL md_xm_bubble[%0d] got=%h exp=0", k, ctrl_xm); n_err++; end
            n_cmp++; if (ctrl_dx !== MD) begin $display("FAIL md_dx_hold[%0d] got=%h exp=%h", k, ctrl_dx, MD); n_err++; end
            n_cmp++; if (stall_fd !== 1'b1) begin $display("FAIL md_stall[%0d] got=%b exp=1", k, stall_fd); n_err++; end
            tick();
        end
        n_cmp++; if (md_busy !== 1'b1) begin $display("FAIL md_busy[4] got=%b exp=1", md_busy); n_err++; end
        n_cmp++; if (ctrl_mw !== 32'h0) begin $display("FAIL md_mw_empty got=%h exp=0", ctrl_mw); n_err++; end
        md_ready = 1'b1; #1;
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL md_ready_stall got=%b exp=0", stall_fd); n_err++; end
        tick();
        md_ready = 1'b0;
        n_cmp++; if (md_busy !== 1'b0) begin $display("FAIL md_release_busy got=%b exp=0", md_busy); n_err++; end
        n_cmp++; if (ctrl_xm !== MD) begin $display("FAIL md_release_xm got=%h exp=%h", ctrl_xm, MD); n_err++; end
        n_cmp++; if (ctrl_dx !== W2) begin $display("FAIL md_release_dx got=%h exp=%h", ctrl_dx, W2); n_err++; end
        n_cmp++; if (md_timeout !== 1'b0) begin $display("FAIL md_no_timeout got=%b exp=0", md_timeout); n_err++; end
        ctrl_fd_in = 32'h0; tick();
    endtask

    task automatic test_md_timeout();
        ctrl_fd_in = MD; tick();
        md_op_dx = 1'b1; ctrl_fd_in = W3; tick();
        md_op_dx = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            n_cmp++; if (md_busy !== 1'b1 || stall_fd !== 1'b1) begin
                $display("FAIL to_wait[%0d] busy=%b stall=%b exp busy=1 stall=1", k, md_busy, stall_fd); n_err++;
            end
            tick();
        end
        n_cmp++; if (md_busy !== 1'b1) begin $display("FAIL to_busy8 got=%b exp=1", md_busy); n_err++; end
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL to_release_stall got=%b exp=0", stall_fd); n_err++; end
        n_cmp++; if (md_timeout !== 1'b0) begin $display("FAIL to_early_flag got=%b exp=0", md_timeout); n_err++; end
        tick();
        n_cmp++; if (md_busy !== 1'b0) begin $display("FAIL to_busy_after got=%b exp=0", md_busy); n_err++; end
        n_cmp++; if (md_timeout !== 1'b1) begin $display("FAIL to_flag got=%b exp=1", md_timeout); n_err++; end
        n_cmp++; if (ctrl_xm !== MD) begin $display("FAIL to_xm got=%h exp=%h", ctrl_xm, MD); n_err++; end
        n_cmp++; if (ctrl_dx !== W3) begin $display("FAIL to_dx got=%h exp=%h", ctrl_dx, W3); n_err++; end
        ctrl_fd_in = 32'h0; tick(); tick(); tick();
        n_cmp++; if (md_timeout !== 1'b1) begin $display("FAIL to_sticky got=%b exp=1", md_timeout); n_err++; end
    endtask

    task automatic test_capture();
        ctrl_fd_in = 32'h3812_0003; tick();
        n_cmp++; if (ctrl_dx !== 32'h0012_0003) begin $display("FAIL capture_rd got=%h exp=00120003", ctrl_dx); n_err++; end
        ctrl_fd_in = 32'h0; tick();
    endtask

    task automatic test_reset_mid_md();
        ctrl_fd_in = MD; tick();
        md_op_dx = 1'b1; ctrl_fd_in = W1; tick();
        md_op_dx = 1'b0; tick();
        n_cmp++; if (md_busy !== 1'b1) begin $display("FAIL rmd_busy_before got=%b exp=1", md_busy); n_err++; end
        reset = 1'b1; #1;
        n_cmp++; if (stall_fd !== 1'b0) begin $display("FAIL rmd_stall got=%b exp=0", stall_fd); n_err++; end
        tick();
        n_cmp++; if (ctrl_dx !== 32'h0 || ctrl_xm !== 32'h0 || ctrl_mw !== 32'h0) begin
            $display("FAIL rmd_regs got dx=%h xm=%h mw=%h exp=0", ctrl_dx, ctrl_xm, ctrl_mw); n_err++;
        end
        n_cmp++; if (md_busy !== 1'b0) begin $display("FAIL rmd_busy got=%b exp=0", md_busy); n_err++; end
        n_cmp++; if (md_timeout !== 1'b0) begin $display("FAIL rmd_timeout got=%b exp=0", md_timeout); n_err++; end
        reset = 1'b0; ctrl_fd_in = 32'h0; tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_load_use();
        test_flush_load();
        test_md_wait();
        test_md_timeout();
        test_capture();
        test_reset_mid_md();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
